// File: rtl/jk_pkg.sv
// Shared JK excitation codes and helpers, used by the stimulus driver and
// by any scoreboard that has to predict what a jk_ff should be fed.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam logic EXC_SR  = 1'b0;
  localparam logic EXC_TGL = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } fsm_e;

  // {j,k} that moves a JK flop from q_cur to q_next in one clock.
  function automatic logic [1:0] jk_excite(input logic q_cur, input logic q_next,
                                           input logic mode);
    logic [1:0] code;
    if (q_cur == q_next) begin
      code = JK_HOLD;
    end else if (mode == EXC_TGL) begin
      code = JK_TOGGLE;
    end else begin
      code = q_next ? JK_SET : JK_RESET;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_stim_driver_if.sv
// Target-bit stream into the driver. Handshake: a bit transfers on a rising
// clk edge where in_valid && in_ready; in_bit is ignored while in_valid is low.
interface jk_stim_driver_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/jk_bit_fifo.sv
// Single-bit-wide synchronous FIFO with registered occupancy count.
// Pop data is the current head, valid whenever the FIFO is non-empty.
module jk_bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_bit,
  input  logic                       pop,
  output logic                       pop_bit,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_bit = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_bit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/jk_stim_driver.sv
// Turns a stream of target Q bits into {j,k} excitation for a downstream
// jk_ff and checks the flop's returned q two edges after each pop.
module jk_stim_driver
  import jk_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int EXC_MODE   = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_stim_driver_if.slave   in_if,
  input  logic              q,
  output logic [1:0]        state,
  output logic              busy,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  output fsm_e              dbg_fsm
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic MODE = (EXC_MODE != 0) ? EXC_TGL : EXC_SR;

  logic          fifo_full, fifo_empty, pop_bit, push, pop;
  logic [CW-1:0] fifo_count;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       state_q, state_d;
  logic             q_model_q, q_model_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic             e1_q, e1_d, e2_q, e2_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             fail;

  assign in_if.in_ready = !fifo_full;
  assign push           = in_if.in_valid && !fifo_full;
  assign pop            = (fsm_q == ST_ISSUE) && !fifo_empty;

  jk_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_bit (in_if.in_bit),
    .pop      (pop),
    .pop_bit  (pop_bit),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ISSUE exactly while the registered FIFO count is non-zero, so a freshly
  // pushed bit pops on the next edge and a steady stream has no bubbles.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (push) fsm_d = ST_ISSUE;
      ST_ISSUE: if (fifo_count == CW'(1) && !push) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // Stage 1 holds the bit whose excitation is on `state`; stage 2 holds the
  // bit the flop has just captured, so q is compared against it.
  always_comb begin
    state_d      = JK_HOLD;
    q_model_d    = q_model_q;
    v1_d         = pop;
    e1_d         = pop_bit;
    v2_d         = v1_q;
    e2_d         = e1_q;
    fail         = v2_q && (q != e2_q);
    mismatch_d   = fail;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q | fail;
    if (pop) begin
      state_d   = jk_excite(q_model_q, pop_bit, MODE);
      q_model_d = pop_bit;
    end
    if (fail && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= ST_IDLE;
      state_q      <= JK_HOLD;
      q_model_q    <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      e1_q         <= 1'b0;
      e2_q         <= 1'b0;
      mismatch_q   <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      q_model_q    <= q_model_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      e1_q         <= e1_d;
      e2_q         <= e2_d;
      mismatch_q   <= mismatch_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign state      = state_q;
  assign busy       = !fifo_empty || v1_q || v2_q;
  assign mismatch   = mismatch_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
  assign dbg_fsm    = fsm_q;
endmodule
